ova_block_sequencer: RTL

Upstream feeder for the overlap-add (OVA) stage of the FFT convolution datapath. Accepts a raster element stream of output blocks from the inverse-transform stage over a valid/ready handshake and assembles each SIZE×SIZE block in a ping-pong buffer. Presents each completed block to the OVA stage as one wide word, tagged with its tile row/column and frame-start flag. Signals frame completion after NUM_BLOCK_ROOT² blocks.

---
 rtl/ova_block_sequencer_if.sv | 37 +++
 rtl/ova_block_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ova_block_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ova_block_sequencer_if                                            |
// | Desc   : Element-in / block-out handshake bundle for ova_block_sequencer.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface ova_block_sequencer_if #(
  parameter int SIZE  = 9,
  parameter int WIDTH = 64,
  parameter int IDXW  = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             in_data;
  logic                         blk_valid;
  logic                         blk_ready;
  logic [SIZE*SIZE*WIDTH-1:0]   blk_data;
  logic [IDXW-1:0]              blk_idx;
  logic [IDXW-1:0]              blk_row;
  logic [IDXW-1:0]              blk_col;
  logic                         blk_first;
  logic                         frame_done;

  // master is the sequencer side: it consumes elements and produces blocks
  modport master (
    input  in_valid, in_data, blk_ready,
    output in_ready, blk_valid, blk_data, blk_idx, blk_row, blk_col,
           blk_first, frame_done
  );

  modport slave (
    output in_valid, in_data, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_idx, blk_row, blk_col,
           blk_first, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/ova_block_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ova_block_sequencer                                               |
// | Desc   : Ping-pong block assembler feeding the overlap-add stage.          |
// |          Optional OVA_SEQ_FLUSH_EN adds a synchronous flush input.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ova_block_sequencer #(
  parameter int NUM_BLOCK_ROOT = 4,
  parameter int SIZE           = 9,
  parameter int WIDTH          = 64,
  parameter int IDXW           = $clog2(NUM_BLOCK_ROOT * NUM_BLOCK_ROOT)
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef OVA_SEQ_FLUSH_EN
  input  logic                   flush,
`endif
  ova_block_sequencer_if.master  bus
);

  localparam int                c_elems    = SIZE * SIZE;
  localparam int                c_kw       = $clog2(c_elems);
  localparam int                c_blocks   = NUM_BLOCK_ROOT * NUM_BLOCK_ROOT;
  localparam logic [c_kw-1:0]   c_k_last   = c_kw'(c_elems - 1);
  localparam logic [IDXW-1:0]   c_idx_last = IDXW'(c_blocks - 1);
  localparam logic [IDXW-1:0]   c_col_last = IDXW'(NUM_BLOCK_ROOT - 1);

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_t;

  buf_state_t                          r_state     [2];
  buf_state_t                          w_state_nxt [2];
  logic                                r_wr_sel;
  logic                                r_rd_sel;
  logic                                r_active;
  logic                                r_frame_done;
  logic [c_kw-1:0]                     r_k;
  logic [IDXW-1:0]                     r_idx;
  logic [IDXW-1:0]                     r_row;
  logic [IDXW-1:0]                     r_col;
  logic [1:0][c_elems-1:0][WIDTH-1:0]  r_buf;

  logic w_flush;
  logic w_in_ready;
  logic w_blk_valid;
  logic w_acc;
  logic w_hs;
  logic w_fill_done;

`ifdef OVA_SEQ_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // r_active holds in_ready low until the first edge after reset release
  assign w_in_ready  = r_active && (r_state[r_wr_sel] != BUF_FULL);
  assign w_blk_valid = (r_state[r_rd_sel] == BUF_FULL);
  assign w_acc       = bus.in_valid && w_in_ready;
  assign w_hs        = w_blk_valid && bus.blk_ready;
  assign w_fill_done = w_acc && (r_k == c_k_last);

  assign bus.in_ready   = w_in_ready;
  assign bus.blk_valid  = w_blk_valid;
  assign bus.blk_data   = r_buf[r_rd_sel];
  assign bus.blk_idx    = r_idx;
  assign bus.blk_row    = r_row;
  assign bus.blk_col    = r_col;
  assign bus.blk_first  = (r_idx == '0);
  assign bus.frame_done = r_frame_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state[0] <= BUF_EMPTY;
      r_state[1] <= BUF_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fill and drain can never target the same buffer in one cycle
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_nxt[b] = r_state[b];
      if (w_flush) begin
        w_state_nxt[b] = BUF_EMPTY;
      end else begin
        if (w_acc && (r_wr_sel == b[0]))
          w_state_nxt[b] = w_fill_done ? BUF_FULL : BUF_FILLING;
        if (w_hs && (r_rd_sel == b[0]))
          w_state_nxt[b] = BUF_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active     <= 1'b0;
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_k          <= '0;
      r_idx        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_frame_done <= 1'b0;
      r_buf        <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_flush) begin
        r_wr_sel     <= 1'b0;
        r_rd_sel     <= 1'b0;
        r_k          <= '0;
        r_idx        <= '0;
        r_row        <= '0;
        r_col        <= '0;
        r_frame_done <= 1'b0;
      end else begin
        r_frame_done <= w_hs && (r_idx == c_idx_last);
        if (w_acc) begin
          r_buf[r_wr_sel][r_k] <= bus.in_data;
          if (w_fill_done) begin
            r_k      <= '0;
            r_wr_sel <= ~r_wr_sel;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        if (w_hs) begin
          r_rd_sel <= ~r_rd_sel;
          if (r_idx == c_idx_last) begin
            r_idx <= '0;
            r_row <= '0;
            r_col <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
            if (r_col == c_col_last) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
